// File: rtl/tdc_run_ctrl.sv
// ---------------------------------------------------------------------------
// tdc_run_ctrl
//
// Run sequencer for the TDC acquisition chain. A start command arms the TDC
// and opens the FIFO write gate. The run ends on a hit-count target, a
// timeout, FIFO full or abort. A short guard window then catches late hits.
// After that the FIFO is drained into framed UART bytes
// (A5, data bytes LSB first, XOR checksum), and a trailer closes the run
// (5A, stop reason, hit count low byte, hit count high byte).
//
// Ports
//   iClk, iRst_n        : clock, asynchronous active-low reset
//   start, abort        : one-cycle command pulses
//   nHits, timeout      : run limits, latched on an accepted start (0 = none)
//   tdc_enable          : TDC arm, high only while acquiring
//   tdc_done            : TDC measurement-complete pulse
//   fifo_wen            : FIFO write enable (combinational from tdc_done)
//   fifo_full/empty     : FIFO status flags
//   fifo_ren, fifo_dout : FIFO read pulse and data (valid one cycle later)
//   tx_byte, tx_valid   : byte stream towards the UART
//   tx_ready            : UART accepts the byte when high
//   busy, run_done      : not-idle flag, end-of-run pulse
//   hit_count           : hits written in the current or last run
//   stop_reason         : 0 COUNT, 1 TIMEOUT, 2 FULL, 3 ABORT
//   overflow            : sticky flag, a hit was dropped on a full FIFO
// ---------------------------------------------------------------------------
module tdc_run_ctrl #(
    parameter int NB_DATA   = 32,
    parameter int N_HITS_W  = 16,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [N_HITS_W-1:0]  nHits,
    input  logic [TIMEOUT_W-1:0] timeout,
    output logic                 tdc_enable,
    input  logic                 tdc_done,
    output logic                 fifo_wen,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    output logic                 fifo_ren,
    input  logic [NB_DATA-1:0]   fifo_dout,
    output logic [7:0]           tx_byte,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 run_done,
    output logic [N_HITS_W-1:0]  hit_count,
    output logic [1:0]           stop_reason,
    output logic                 overflow
);

    localparam int         NBYTES   = NB_DATA / 8;
    // Byte index of the checksum inside a data frame (0 is the A5 header)
    localparam logic [7:0] CSUM_IDX = 8'(NBYTES + 1);

    localparam logic [1:0] REASON_COUNT   = 2'd0;
    localparam logic [1:0] REASON_TIMEOUT = 2'd1;
    localparam logic [1:0] REASON_FULL    = 2'd2;
    localparam logic [1:0] REASON_ABORT   = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACQ,
        S_GUARD,
        S_CHK,
        S_RD,
        S_LATCH,
        S_SEND,
        S_TRAIL,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [N_HITS_W-1:0]   nhits_lat;
    logic [TIMEOUT_W-1:0]  timeout_lat;
    logic [TIMEOUT_W-1:0]  timer;
    logic [TIMEOUT_W-1:0]  timer_inc;
    logic [N_HITS_W-1:0]   hit_inc;
    logic [15:0]           hit_count16;
    logic                  guard_cnt;
    logic [7:0]            byte_idx;
    logic [NB_DATA-1:0]    shift_reg;
    logic [7:0]            checksum;

    logic                  capture;
    logic                  stop_count;
    logic                  stop_timeout;
    logic                  acq_stop;
    logic [1:0]            acq_reason;
    logic                  kill;
    logic                  tx_accept;

    // Hits are accepted both while acquiring and during the guard window,
    // so pulses already in flight when the TDC is disarmed are not lost.
    assign capture      = (state == S_ACQ) || (state == S_GUARD);
    assign fifo_wen     = capture && tdc_done && !fifo_full;
    assign hit_inc      = hit_count + N_HITS_W'(1);
    assign timer_inc    = timer + TIMEOUT_W'(1);
    // The write being made this cycle is the one that completes the target
    assign stop_count   = (nhits_lat != '0) && fifo_wen && (hit_inc == nhits_lat);
    assign stop_timeout = (timeout_lat != '0) && (timer_inc == timeout_lat);
    // DONE already pulses run_done, so an abort there changes nothing
    assign kill         = abort && (state != S_IDLE) && (state != S_DONE);
    assign tx_accept    = tx_valid && tx_ready;
    assign busy         = (state != S_IDLE);
    assign hit_count16  = 16'(hit_count);

    // State register of the run sequencer.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode. Stop causes are ranked COUNT, TIMEOUT,
    // FULL inside ACQ; abort overrides everything in any active state.
    always_comb begin
        state_next = state;
        tdc_enable = 1'b0;
        fifo_ren   = 1'b0;
        tx_valid   = 1'b0;
        tx_byte    = 8'h00;
        run_done   = 1'b0;
        acq_stop   = stop_count || stop_timeout || fifo_full;
        acq_reason = REASON_FULL;
        if (stop_count) begin
            acq_reason = REASON_COUNT;
        end else if (stop_timeout) begin
            acq_reason = REASON_TIMEOUT;
        end

        case (state)
            S_IDLE: begin
                if (start) state_next = S_ACQ;
            end
            S_ACQ: begin
                tdc_enable = 1'b1;
                if (acq_stop) state_next = S_GUARD;
            end
            S_GUARD: begin
                if (guard_cnt) state_next = S_CHK;
            end
            S_CHK: begin
                state_next = fifo_empty ? S_TRAIL : S_RD;
            end
            S_RD: begin
                fifo_ren   = 1'b1;
                state_next = S_LATCH;
            end
            S_LATCH: begin
                state_next = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                if (byte_idx == 8'd0) begin
                    tx_byte = 8'hA5;
                end else if (byte_idx == CSUM_IDX) begin
                    tx_byte = checksum;
                end else begin
                    tx_byte = shift_reg[7:0];
                end
                if (tx_accept && (byte_idx == CSUM_IDX)) state_next = S_CHK;
            end
            S_TRAIL: begin
                tx_valid = 1'b1;
                case (byte_idx)
                    8'd0:    tx_byte = 8'h5A;
                    8'd1:    tx_byte = {6'b0, stop_reason};
                    8'd2:    tx_byte = hit_count16[7:0];
                    default: tx_byte = hit_count16[15:8];
                endcase
                if (tx_accept && (byte_idx == 8'd3)) state_next = S_DONE;
            end
            S_DONE: begin
                run_done   = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (kill) state_next = S_DONE;
    end

    // Run datapath: latched limits, timer, hit bookkeeping, guard counter and
    // the frame serializer. Data bytes leave the shift register LSB first and
    // are folded into the checksum as each one is accepted.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            nhits_lat   <= '0;
            timeout_lat <= '0;
            timer       <= '0;
            hit_count   <= '0;
            stop_reason <= REASON_COUNT;
            overflow    <= 1'b0;
            guard_cnt   <= 1'b0;
            byte_idx    <= 8'd0;
            shift_reg   <= '0;
            checksum    <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        nhits_lat   <= nHits;
                        timeout_lat <= timeout;
                        timer       <= '0;
                        hit_count   <= '0;
                        overflow    <= 1'b0;
                        stop_reason <= REASON_COUNT;
                    end
                end
                S_ACQ: begin
                    timer     <= timer_inc;
                    guard_cnt <= 1'b0;
                    if (acq_stop) stop_reason <= acq_reason;
                end
                S_GUARD: begin
                    guard_cnt <= 1'b1;
                end
                S_CHK: begin
                    byte_idx <= 8'd0;
                end
                S_LATCH: begin
                    shift_reg <= fifo_dout;
                    checksum  <= 8'h00;
                end
                S_SEND: begin
                    if (tx_accept) begin
                        if ((byte_idx != 8'd0) && (byte_idx != CSUM_IDX)) begin
                            shift_reg <= shift_reg >> 8;
                            checksum  <= checksum ^ shift_reg[7:0];
                        end
                        byte_idx <= (byte_idx == CSUM_IDX) ? 8'd0 : byte_idx + 8'd1;
                    end
                end
                S_TRAIL: begin
                    if (tx_accept) byte_idx <= byte_idx + 8'd1;
                end
                default: begin
                end
            endcase

            // Saturating hit counter; a dropped hit marks the run as lossy
            if (fifo_wen && !(&hit_count)) hit_count <= hit_inc;
            if (capture && tdc_done && fifo_full) overflow <= 1'b1;
            if (kill) stop_reason <= REASON_ABORT;
        end
    end

endmodule
